// File: rtl/bc_buffer.sv
// Dual-channel buffer between the avoid and ctrl sides.
// Each direction has its own synchronous FIFO with a registered read port.
// A pop loads the head word into out_data on the popping edge, so this is
// not first-word-fall-through. Writes to a full FIFO and pops from an empty
// FIFO are ignored.

module bc_buffer_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  wr_en;
  logic                  rd_en;

  // Full and empty are judged on the count before this edge. A write
  // arriving while full is therefore dropped even if a pop frees a slot on
  // the same edge. A pop arriving while empty likewise cannot see a word
  // that is written on that same edge.
  assign wr_en = in_valid && (count != FULL_CNT);
  assign rd_en = out_rdy && (count != '0);

  // Storage array; contents are don't-care after reset, so it has no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // Write pointer; wraps naturally modulo DEPTH (power of two)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + AW'(1);
  end

  // Read pointer and registered read port; out_data holds when no pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      out_data <= '0;
    end else if (rd_en) begin
      rd_ptr   <= rd_ptr + AW'(1);
      out_data <= mem[rd_ptr];
    end
  end

  // Occupancy count; a simultaneous write and pop leave it unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module bc_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  avoid_in_valid,
  input  logic [DATA_WIDTH-1:0] avoid_in_data,
  input  logic                  ctrl_out_rdy,
  output logic [DATA_WIDTH-1:0] ctrl_out_data,
  input  logic                  ctrl_in_valid,
  input  logic [DATA_WIDTH-1:0] ctrl_in_data,
  input  logic                  avoid_out_rdy,
  output logic [DATA_WIDTH-1:0] avoid_out_data
);

  // Forward channel: avoid side writes, ctrl side reads
  bc_buffer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .in_valid (avoid_in_valid),
    .in_data  (avoid_in_data),
    .out_rdy  (ctrl_out_rdy),
    .out_data (ctrl_out_data)
  );

  // Return channel: ctrl side writes, avoid side reads
  bc_buffer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ret (
    .clk      (clk),
    .rst      (rst),
    .in_valid (ctrl_in_valid),
    .in_data  (ctrl_in_data),
    .out_rdy  (avoid_out_rdy),
    .out_data (avoid_out_data)
  );

endmodule

// File: tb/tb_bc_buffer.sv
// Directed testbench for bc_buffer (DATA_WIDTH=16, DEPTH=16).
module tb_bc_buffer;

  logic        clk;
  logic        run;
  logic        rst;
  logic        avoid_in_valid;
  logic [15:0] avoid_in_data;
  logic        ctrl_out_rdy;
  logic [15:0] ctrl_out_data;
  logic        ctrl_in_valid;
  logic [15:0] ctrl_in_data;
  logic        avoid_out_rdy;
  logic [15:0] avoid_out_data;

  int n_cmp;
  int n_err;

  bc_buffer #(
    .DATA_WIDTH (16),
    .DEPTH      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .avoid_in_valid (avoid_in_valid),
    .avoid_in_data  (avoid_in_data),
    .ctrl_out_rdy   (ctrl_out_rdy),
    .ctrl_out_data  (ctrl_out_data),
    .ctrl_in_valid  (ctrl_in_valid),
    .ctrl_in_data   (ctrl_in_data),
    .avoid_out_rdy  (avoid_out_rdy),
    .avoid_out_data (avoid_out_data)
  );

  // The clock stays low until run is set, so reset can be checked without clock edges
  initial clk = 1'b0;
  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    run = 1'b0;
    rst = 1'b0;
    avoid_in_valid = 1'b0; avoid_in_data = '0; ctrl_out_rdy = 1'b0;
    ctrl_in_valid = 1'b0;  ctrl_in_data = '0;  avoid_out_rdy = 1'b0;

    // Reset is asserted with no clock running
    #3;
    check_val("rst_noclk_ctrl", ctrl_out_data, 16'h0000);
    check_val("rst_noclk_avoid", avoid_out_data, 16'h0000);
    run = 1'b1;
    step(); step();
    rst = 1'b1;
    ctrl_out_rdy = 1'b1; avoid_out_rdy = 1'b1;
    step(); step();
    check_val("post_rst_pop_ctrl", ctrl_out_data, 16'h0000);
    check_val("post_rst_pop_avoid", avoid_out_data, 16'h0000);
    ctrl_out_rdy = 1'b0; avoid_out_rdy = 1'b0;

    // Return burst of 10..19, then two idle cycles, then continuous pops
    for (int i = 0; i < 10; i++) begin
      ctrl_in_valid = 1'b1; ctrl_in_data = 16'(10 + i);
      step();
    end
    ctrl_in_valid = 1'b0;
    step(); step();
    avoid_out_rdy = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_val($sformatf("ret_burst_%0d", k), avoid_out_data, 16'(10 + k - 1));
    end
    step(); check_val("ret_extra_pop1", avoid_out_data, 16'h0013);
    step(); check_val("ret_extra_pop2", avoid_out_data, 16'h0013);
    avoid_out_rdy = 1'b0;
    check_val("ret_burst_fwd_untouched", ctrl_out_data, 16'h0000);

    // Forward burst of 17 words; the 17th is dropped because the FIFO is full
    for (int i = 0; i < 17; i++) begin
      avoid_in_valid = 1'b1; avoid_in_data = 16'(16'h0100 + i);
      step();
    end
    avoid_in_valid = 1'b0;
    // The first pop happens while the FIFO is full: the pop occurs and 0x0999 is dropped
    ctrl_out_rdy = 1'b1;
    avoid_in_valid = 1'b1; avoid_in_data = 16'h0999;
    step();
    avoid_in_valid = 1'b0;
    check_val("fwd_ovf_pop1", ctrl_out_data, 16'h0100);
    for (int k = 2; k <= 17; k++) begin
      step();
      check_val($sformatf("fwd_ovf_pop%0d", k), ctrl_out_data, (k <= 16) ? 16'(16'h0100 + k - 1) : 16'h010F);
    end
    ctrl_out_rdy = 1'b0;

    // Streaming: write and pop on the same edge while the FIFO is empty; only the write happens
    avoid_in_valid = 1'b1; avoid_in_data = 16'h0001; ctrl_out_rdy = 1'b1;
    step();
    check_val("stream_empty_rw_hold", ctrl_out_data, 16'h010F);
    for (int i = 2; i <= 11; i++) begin
      avoid_in_data = 16'(i);
      step();
      check_val($sformatf("stream_%0d", i - 1), ctrl_out_data, 16'(i - 1));
    end
    avoid_in_valid = 1'b0;
    step(); check_val("stream_last", ctrl_out_data, 16'h000B);
    step(); check_val("stream_drained_hold", ctrl_out_data, 16'h000B);
    ctrl_out_rdy = 1'b0;

    // Independence: 4 forward words and 3 return words, each channel drained separately
    for (int i = 0; i < 4; i++) begin
      avoid_in_valid = 1'b1; avoid_in_data = 16'(16'hAAA0 + i);
      ctrl_in_valid = (i < 3); ctrl_in_data = 16'(16'h5550 + i);
      step();
    end
    avoid_in_valid = 1'b0; ctrl_in_valid = 1'b0;
    ctrl_out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_val($sformatf("indep_fwd_%0d", k), ctrl_out_data, (k < 4) ? 16'(16'hAAA0 + k) : 16'hAAA3);
    end
    ctrl_out_rdy = 1'b0;
    check_val("indep_ret_untouched", avoid_out_data, 16'h0013);
    avoid_out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_val($sformatf("indep_ret_%0d", k), avoid_out_data, (k < 3) ? 16'(16'h5550 + k) : 16'h5552);
    end
    avoid_out_rdy = 1'b0;
    check_val("indep_fwd_untouched", ctrl_out_data, 16'hAAA3);

    // Reset pulse in mid-operation discards the 5 stored words on each channel
    for (int i = 0; i < 5; i++) begin
      avoid_in_valid = 1'b1; avoid_in_data = 16'(16'h0700 + i);
      ctrl_in_valid = 1'b1;  ctrl_in_data = 16'(16'h0800 + i);
      step();
    end
    avoid_in_valid = 1'b0; ctrl_in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_val("midrst_ctrl_zero", ctrl_out_data, 16'h0000);
    check_val("midrst_avoid_zero", avoid_out_data, 16'h0000);
    #1 rst = 1'b1;
    ctrl_out_rdy = 1'b1; avoid_out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val($sformatf("midrst_pop_ctrl_%0d", k), ctrl_out_data, 16'h0000);
      check_val($sformatf("midrst_pop_avoid_%0d", k), avoid_out_data, 16'h0000);
    end
    ctrl_out_rdy = 1'b0; avoid_out_rdy = 1'b0;
    avoid_in_valid = 1'b1; avoid_in_data = 16'h0777;
    step();
    avoid_in_valid = 1'b0; ctrl_out_rdy = 1'b1;
    step();
    check_val("midrst_new_write", ctrl_out_data, 16'h0777);
    ctrl_out_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
